// File: rtl/sp_ram_clr.sv
// rtl/sp_ram_clr.sv - synchronous single-port RAM with byte enables, registered read and clear sweep
// Optional per-lane parity storage and checking when RAM_PARITY_EN is defined.
module sp_ram_clr #(
    parameter  int DATA_WIDTH = 16,
    parameter  int ADDR_WIDTH = 16,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic                  clear,
    output logic                  ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  q_valid
`ifdef RAM_PARITY_EN
    ,
    input  logic                  err_inj,
    output logic [BE_WIDTH-1:0]   perr
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic                  sweep_last;
    logic                  acc_wr;
    logic                  acc_rd;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
    logic [BE_WIDTH-1:0]   par [DEPTH];
`endif

    assign busy       = (state == S_CLEAR);
    // clear has priority over a same-cycle request, so it masks ready
    assign ready      = (state == S_IDLE) && !clear;
    assign acc_wr     = req && ready && write;
    assign acc_rd     = req && ready && !write;
    assign sweep_last = (cnt == (ADDR_WIDTH+1)'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_CLEAR: begin
                cnt_nxt = cnt + (ADDR_WIDTH+1)'(1);
                if (sweep_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clear) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Storage has no reset; the sweep is what defines its contents.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt[ADDR_WIDTH-1:0]] <= '0;
`ifdef RAM_PARITY_EN
            par[cnt[ADDR_WIDTH-1:0]] <= '0;
`endif
        end else if (acc_wr) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= data[8*k +: 8];
`ifdef RAM_PARITY_EN
                    par[addr][k] <= (^data[8*k +: 8]) ^ err_inj;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q       <= '0;
            q_valid <= 1'b0;
`ifdef RAM_PARITY_EN
            perr    <= '0;
`endif
        end else begin
            q_valid <= acc_rd;
            if (acc_rd) begin
                Q <= mem[addr];
`ifdef RAM_PARITY_EN
                for (int k = 0; k < BE_WIDTH; k++) begin
                    perr[k] <= par[addr][k] ^ (^mem[addr][8*k +: 8]);
                end
`endif
            end
        end
    end

endmodule
